// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 encodings and lane helpers for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // Exactly one of read/write, a defined size for that direction, natural alignment.
  function automatic logic access_legal(input logic rd, input logic wr,
                                        input logic [2:0] f3, input logic [1:0] alo);
    logic ok;
    ok = 1'b0;
    if (rd ^ wr) begin
      case (f3)
        LS_B:    ok = 1'b1;
        LS_H:    ok = !alo[0];
        LS_W:    ok = (alo == 2'b00);
        LS_BU:   ok = rd;
        LS_HU:   ok = rd && !alo[0];
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] alo);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << alo;
      2'b01:   be = 4'b0011 << alo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/grant/response memory bus between the LSU and memory
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - selects the addressed byte/half of a read word and extends it
module load_formatter
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    data = rdata;
    case (funct3)
      LS_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LS_BU:   data = {24'h0, byte_sel};
      LS_H:    data = {{16{half_sel[15]}}, half_sel};
      LS_HU:   data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit stalling the core across a bus transaction
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        store_data,
  output logic [31:0]        load_data,
  output logic               stall,
  output logic               access_fault,
  output logic               bus_error,
  load_store_unit_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  lsu_state_t    state;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    alo_q;
  logic          req_q, we_q;
  logic [31:0]   addr_q, wdata_q, fmt_data;
  logic [3:0]    be_q;
  logic          access, legal, timed_out;

  assign access       = mem_read | mem_write;
  assign legal        = access_legal(mem_read, mem_write, funct3, addr[1:0]);
  assign access_fault = (state == IDLE) && access && !legal;
  assign stall        = ((state == IDLE) && legal) || (state == REQ) || (state == WAIT);
  assign timed_out    = (cnt >= CNT_LAST);

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

  load_formatter u_fmt (
    .funct3  (f3_q),
    .addr_lo (alo_q),
    .rdata   (bus.bus_rdata),
    .data    (fmt_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_q      <= 3'b000;
      alo_q     <= 2'b00;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      be_q      <= 4'h0;
      wdata_q   <= 32'h0;
      load_data <= 32'h0;
      bus_error <= 1'b0;
    end else begin
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (legal) begin
            addr_q  <= {addr[31:2], 2'b00};
            we_q    <= mem_write;
            be_q    <= lane_be(funct3, addr[1:0]);
            wdata_q <= lane_wdata(funct3, store_data);
            f3_q    <= funct3;
            alo_q   <= addr[1:0];
            cnt     <= '0;
            req_q   <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          // A grant on the last allowed cycle still wins; the counter keeps running in WAIT.
          if (bus.bus_gnt) begin
            req_q <= 1'b0;
            state <= WAIT;
          end else if (timed_out) begin
            req_q     <= 1'b0;
            bus_error <= 1'b1;
            if (!we_q) load_data <= 32'h0;
            state     <= DONE;
          end
        end
        WAIT: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (bus.bus_rvalid) begin
            if (!we_q) load_data <= fmt_data;
            state <= DONE;
          end else if (timed_out) begin
            bus_error <= 1'b1;
            if (!we_q) load_data <= 32'h0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized scoreboard bench for load_store_unit
module tb_load_store_unit;

  localparam int T = 4;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] ld;
    logic        err;
    int          stalls;
  } res_t;

  logic        clk, reset, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, load_data;
  logic        stall, access_fault, bus_error;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .load_data    (load_data),
    .stall        (stall),
    .access_fault (access_fault),
    .bus_error    (bus_error),
    .bus          (bus_if)
  );

  int          checks = 0;
  int          failures = 0;
  req_t        req_q[$];
  res_t        res_q[$];
  bit          fault_q[$];
  logic [31:0] model_ld = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s got=event exp=none", name);
  endtask

  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [1:0] alo,
                                           input int size, input bit sgn);
    logic [31:0] v, mask;
    v = rdata >> (8 * int'(alo));
    if (size == 4) return v;
    mask = (32'h1 << (8 * size)) - 32'h1;
    v = v & mask;
    if (sgn && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  // Issue one instruction; g = REQ cycle index of the grant, w = WAIT cycles before rvalid.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int g, input int w, input logic [31:0] rdata);
    int   size, limit, ridx, cycles, idx;
    bit   sgn, load_only, known, ok, tmo;
    req_t rq;
    res_t rs;
    size = 1; sgn = 0; load_only = 0; known = 1;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: begin size = 1; load_only = 1; end
      3'd5: begin size = 2; load_only = 1; end
      default: known = 0;
    endcase
    ok = (rd != wr) && known && !(load_only && wr) && ((int'(a[1:0]) % size) == 0);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'($urandom_range(0, 1)); bus_if.bus_rdata = rdata;
    if (!ok) begin
      fault_q.push_back(1'b1);
      return;
    end
    rq.addr = {a[31:2], 2'b00};
    rq.we   = wr;
    rq.be   = 4'((32'h1 << size) - 1) << a[1:0];
    for (int i = 0; i < 4; i++) rq.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
    req_q.push_back(rq);
    if (g >= T) begin
      tmo = 1; cycles = T; ridx = -1;
    end else begin
      limit = (T - 1 > g + 1) ? T - 1 : g + 1;
      ridx  = g + 1 + w;
      tmo   = (ridx > limit);
      cycles = tmo ? limit + 1 : ridx + 1;
    end
    if (rd) model_ld = tmo ? 32'h0 : fmt_load(rdata, a[1:0], size, sgn);
    rs.ld = model_ld; rs.err = tmo; rs.stalls = 1 + cycles;
    res_q.push_back(rs);
    for (idx = 0; idx < 100; idx++) begin
      @(posedge clk); #1;
      bus_if.bus_gnt    = (idx == g);
      bus_if.bus_rvalid = (idx == ridx) || (idx <= g && $urandom_range(0, 1) == 1);
      #1;
      if (!stall) break;
    end
    if (idx >= 100) fail_now("stall_never_dropped");
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
  endtask

  task automatic do_idle();
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
    bus_if.bus_gnt = 1'($urandom_range(0, 1));
    bus_if.bus_rvalid = 1'($urandom_range(0, 1));
  endtask

  task automatic reset_mid(input bit in_wait);
    req_t rq;
    @(posedge clk); #1;
    mem_read = 1; mem_write = 0; funct3 = 3'd2; addr = 32'h200; store_data = 32'h0;
    bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0;
    if (in_wait) begin
      rq.addr = 32'h200; rq.we = 0; rq.be = 4'hF; rq.wdata = 32'h0;
      req_q.push_back(rq);
    end
    @(posedge clk); #1;
    bus_if.bus_gnt = in_wait;
    if (in_wait) begin
      @(posedge clk); #1;
      bus_if.bus_gnt = 0;
    end
    #2 reset = 0;
    #1;
    check("rst_mid_bus_req", 32'(bus_if.bus_req), 32'h0);
    check("rst_mid_idle_stall", 32'(stall), 32'h1);
    mem_read = 0;
    model_ld = 32'h0;
    @(posedge clk); #1;
    reset = 1; bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus_if.bus_rvalid = 0;
    #1;
    check("rst_stray_rvalid_load_data", load_data, model_ld);
    check("rst_after_stall", 32'(stall), 32'h0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT starts a request, faults or retires.
  bit prev_req = 0, prev_stall = 0;
  int stall_run = 0;
  always @(negedge clk) begin
    req_t rq;
    res_t rs;
    if (!reset) begin
      prev_req = 0; prev_stall = 0; stall_run = 0;
    end else begin
      if (bus_if.bus_req && !prev_req) begin
        if (req_q.size() == 0) fail_now("unexpected_bus_req");
        else begin
          rq = req_q.pop_front();
          check("req_addr", bus_if.bus_addr, rq.addr);
          check("req_we", 32'(bus_if.bus_we), 32'(rq.we));
          check("req_be", 32'(bus_if.bus_be), 32'(rq.be));
          if (rq.we) check("req_wdata", bus_if.bus_wdata, rq.wdata);
        end
      end
      if (access_fault) begin
        if (fault_q.size() == 0) fail_now("unexpected_access_fault");
        else begin
          void'(fault_q.pop_front());
          check("fault_stall", 32'(stall), 32'h0);
        end
      end
      if (stall) stall_run++;
      else if (prev_stall) begin
        if (res_q.size() == 0) fail_now("unexpected_retire");
        else begin
          rs = res_q.pop_front();
          check("retire_load_data", load_data, rs.ld);
          check("retire_bus_error", 32'(bus_error), 32'(rs.err));
          check("retire_stall_cycles", 32'(stall_run), 32'(rs.stalls));
        end
        stall_run = 0;
      end else check("bus_error_outside_done", 32'(bus_error), 32'h0);
      prev_req = bus_if.bus_req;
      prev_stall = stall;
    end
  end

  initial begin
    int k;
    logic [2:0]  f3r;
    logic [2:0]  legal_f3 [5];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2; legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
    reset = 0; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; store_data = 0;
    bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0; bus_if.bus_rdata = 0;
    #12;
    check("reset_load_data", load_data, 32'h0);
    check("reset_bus_req", 32'(bus_if.bus_req), 32'h0);
    check("reset_bus_we", 32'(bus_if.bus_we), 32'h0);
    check("reset_bus_error", 32'(bus_error), 32'h0);
    check("reset_bus_addr", bus_if.bus_addr, 32'h0);
    check("reset_bus_be", 32'(bus_if.bus_be), 32'h0);
    check("reset_bus_wdata", bus_if.bus_wdata, 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    @(posedge clk); #1 reset = 1;

    do_access(1, 0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    do_access(0, 1, 3'd0, 32'h103, 32'hA5, 0, 0, 32'h0);
    do_access(1, 0, 3'd0, 32'h102, 32'h0, 0, 0, 32'h0080FF00);
    do_access(1, 0, 3'd4, 32'h102, 32'h0, 1, 1, 32'h0080FF00);
    do_access(1, 0, 3'd1, 32'h102, 32'h0, 0, 0, 32'h0080FF00);
    do_access(1, 0, 3'd5, 32'h100, 32'h0, 0, 0, 32'h0080FF00);
    do_access(0, 1, 3'd1, 32'h102, 32'h12345678, 0, 0, 32'h0);
    do_access(1, 0, 3'd1, 32'h101, 32'h0, 0, 0, 32'h0);
    do_access(0, 1, 3'd2, 32'h102, 32'h0, 0, 0, 32'h0);
    do_access(1, 1, 3'd2, 32'h100, 32'h0, 0, 0, 32'h0);
    do_access(0, 1, 3'd4, 32'h100, 32'h0, 0, 0, 32'h0);
    do_access(1, 0, 3'd2, 32'h104, 32'h0, 0, 20, 32'h11111111);
    do_access(1, 0, 3'd2, 32'h108, 32'h0, 0, 2, 32'h22222222);
    do_access(1, 0, 3'd2, 32'h10C, 32'h0, 3, 0, 32'h33333333);
    do_access(1, 0, 3'd2, 32'h110, 32'h0, 9, 0, 32'h44444444);
    do_access(0, 1, 3'd2, 32'h114, 32'hCAFEF00D, 0, 9, 32'h0);
    reset_mid(1'b1);
    reset_mid(1'b0);

    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 19);
      if (k < 2) do_idle();
      else begin
        f3r = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
        do_access(k == 2 || k < 11, k == 2 || k >= 11, f3r,
                  32'h1000 | ($urandom & 32'hFFF), $urandom,
                  $urandom_range(0, 5), $urandom_range(0, 4), $urandom);
      end
    end

    do_idle();
    do_idle();
    do_idle();
    check("req_queue_drained", 32'(req_q.size()), 32'h0);
    check("res_queue_drained", 32'(res_q.size()), 32'h0);
    check("fault_queue_drained", 32'(fault_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the single-cycle datapath and a request/grant/response memory bus, replacing the zero-wait data memory. It takes the ALU-computed address, store data and memory enables, performs byte-lane steering and load sign/zero-extension, and stalls the core until the bus transaction completes. It also flags misaligned or illegal accesses and bus timeouts.

## Interface
- TIMEOUT, 255: max cycles spent in REQ+WAIT before abort (≥1)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 forces IDLE immediately
- mem_read  in  1  load request from controller (read_enable)
- mem_write  in  1  store request from controller (write_enable)
- funct3  in  3  access size/sign, instruction[14:12]
- addr  in  32  byte address (ALU_result)
- store_data  in  32  rs2 value (rdata2)
- load_data  out  32  formatted load result, registered
- stall  out  1  holds PC and register write while high
- access_fault  out  1  combinational, illegal access this cycle
- bus_error  out  1  one-cycle pulse, transaction timed out
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response/ack (reads and writes)
- bus_rdata  in  32  read data

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: access = mem_read|mem_write. Legal access → latch bus_addr/we/be/wdata, funct3, addr[1:0]; go REQ. Otherwise stay.
- access_fault (IDLE only): mem_read&mem_write; reserved funct3 (load: 011,110,111; store: any except 000,001,010); LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0. Faulting access: no bus activity, stall=0, instruction retires as no-op.
- REQ: bus_req=1, outputs stable. bus_gnt=1 → WAIT.
- WAIT: bus_req=0. bus_rvalid=1 → capture formatted bus_rdata into load_data (loads only; stores leave load_data unchanged) → DONE.
- DONE: stall=0 for exactly one cycle (instruction retires, core writes load_data back); → IDLE.
- stall = (IDLE & legal access) | REQ | WAIT.
- Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{store_data[7:0]}}; SH be=4'b0011<<addr[1:0], wdata={2{store_data[15:0]}}; SW be=4'hF, wdata=store_data.
- Load format: byte = bus_rdata[8*addr[1:0]+:8], half = bus_rdata[16*addr[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through. Load be as store of same size.
- Timeout: counter cleared on entering REQ, increments each REQ/WAIT cycle; reaching TIMEOUT without completion → DONE, load_data=0 (loads), bus_error=1 in that DONE cycle, bus_req dropped.

## Timing
- Reset values: state IDLE, load_data 0, bus_req/bus_we/bus_error 0, bus_addr/bus_be/bus_wdata 0, counter 0; access_fault/stall per IDLE logic.
- Minimum access: cycle 0 IDLE (stall=1), cycle 1 REQ with gnt, cycle 2 WAIT with rvalid, cycle 3 DONE (retire). Three stall cycles.
- bus_gnt may be high in first REQ cycle. bus_rvalid only honoured in WAIT; rvalid in REQ or IDLE is ignored.
- gnt and timeout same cycle: gnt wins (→WAIT, counter continues). rvalid and timeout same cycle: rvalid wins, no bus_error.
- Back-to-back accesses: next instruction's access detected in the IDLE cycle following DONE.
- Reset mid-transaction: bus_req falls asynchronously; any later rvalid is ignored.
- Counter width $clog2(TIMEOUT+1).

## Structure
- Package lsu_pkg: state enum (IDLE, REQ, WAIT, DONE); funct3 constants LS_B=000, LS_H=001, LS_W=010, LS_BU=100, LS_HU=101.
- Sub-module load_formatter: combinational, inputs funct3, addr[1:0], bus_rdata; output 32-bit formatted word.

## Test plan
- LW addr=0x100, gnt in REQ cycle 1, rvalid next → bus_addr=0x100, be=F, stall high 3 cycles, load_data=bus_rdata=0xDEADBEEF in DONE.
- SB addr=0x103, store_data=0x000000A5 → be=4'b1000, wdata=0xA5A5A5A5, bus_we=1, load_data unchanged.
- LB addr=0x102, rdata=0x0080FF00 → load_data=0xFFFFFF80; LBU same → 0x00000080; LH addr=0x102 → 0x00000080; LHU addr=0x100 → 0x0000FF00.
- LH addr=0x101 and SW addr=0x102 → access_fault=1, stall=0, bus_req never asserts.
- TIMEOUT=4, gnt given, rvalid withheld → DONE after 4 REQ/WAIT cycles, bus_error one pulse, load_data=0; rvalid coinciding with 4th cycle → no bus_error.
- Reset low during WAIT → bus_req=0, state IDLE immediately; subsequent stray rvalid does not change load_data.
